memory_latency_responder: RTL and testbench

Data-memory responder for the core's data-side request/grant/rvalid interface. It accepts core requests, services them from a small internal word RAM, and returns each response a programmable number of cycles after its grant. Tests use it to plant known request-to-rvalid gaps, which the memory gap counter then measures. It sits in simulation and FPGA test harnesses in place of the real data memory.

---
 rtl/memory_responder_pkg.sv | 25 ++
 rtl/memory_latency_responder_response_queue.sv | 51 +++++
 rtl/memory_latency_responder.sv | 131 +++++++++++++
 tb/tb_memory_latency_responder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_responder_pkg.sv
// Shared types and constants for the memory latency responder.
package memory_responder_pkg;

    typedef struct packed {
        logic [31:0] rdata;
        logic [31:0] due;
    } resp_entry_t;

    localparam logic [15:0] LFSR_SEED   = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;
    localparam logic [15:0] MIN_LATENCY = 16'd1;

    // Galois form of x^16+x^14+x^13+x^11+1
    function automatic logic [15:0] lfsr_next(input logic [15:0] state);
        return {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    // Wrap-safe "deadline reached": signed (deadline - t) <= 0
    function automatic logic is_due(input logic [31:0] deadline, input logic [31:0] t);
        logic [31:0] diff;
        diff = deadline - t;
        return $signed(diff) <= 32'sd0;
    endfunction

endpackage

// File: rtl/memory_latency_responder_response_queue.sv
// In-order response FIFO; payload storage is deliberately left unreset.
module response_queue
    import memory_responder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  resp_entry_t              push_data,
    output resp_entry_t              head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);

    resp_entry_t     slots_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     count_r;

    // Pointer and occupancy tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) wr_ptr_r <= wr_ptr_r + AW'(1);
            else      wr_ptr_r <= wr_ptr_r;
            if (pop)  rd_ptr_r <= rd_ptr_r + AW'(1);
            else      rd_ptr_r <= rd_ptr_r;
            case ({push, pop})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        if (push) slots_r[wr_ptr_r] <= push_data;
    end

    assign head  = slots_r[rd_ptr_r];
    assign count = count_r;
    assign full  = (count_r == (AW+1)'(DEPTH));

endmodule

// File: rtl/memory_latency_responder.sv
// Data-memory responder returning each response a programmable latency after grant.
// Optional random grant stalls are enabled by defining RESPONDER_STALL_EN.
module memory_latency_responder
    import memory_responder_pkg::*;
#(
    parameter int MEM_WORDS       = 1024,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_mem_req,
    input  logic [31:0] data_mem_addr,
    input  logic        data_mem_we,
    input  logic [3:0]  data_mem_be,
    input  logic [31:0] data_mem_wdata,
    output logic        data_mem_gnt,
    output logic        data_mem_rvalid,
    output logic [31:0] data_mem_rdata,
    input  logic [15:0] resp_latency,
    output logic        queue_full
);
    localparam int IW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

    logic [31:0]    mem_r [MEM_WORDS];
    logic [31:0]    now_r;
    logic [31:0]    last_due_r;
    logic           rvalid_r;
    logic [31:0]    rdata_r;

    logic [IW-1:0]  idx_s;
    logic [31:0]    rd_word_s;
    logic [15:0]    lat_s;
    logic [31:0]    now_next_s;
    logic [31:0]    cand_s;
    logic [31:0]    chain_s;
    logic [31:0]    due_s;
    logic           pop_s;
    logic           push_s;
    logic           bypass_s;
    logic           gnt_s;
    logic           full_or_draining_s;
    logic           stall_s;
    logic           full_s;
    logic [CW-1:0]  count_s;
    resp_entry_t    head_s;
    resp_entry_t    push_data_s;
    logic           unused_addr_s;

    assign idx_s         = data_mem_addr[IW+1:2];
    assign unused_addr_s = ^{data_mem_addr[31:IW+2], data_mem_addr[1:0]};

`ifdef RESPONDER_STALL_EN
    logic [15:0] lfsr_r;

    // Free-running stall generator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_r <= LFSR_SEED;
        else     lfsr_r <= lfsr_next(lfsr_r);
    end

    assign stall_s = lfsr_r[0];
`else
    assign stall_s = 1'b0;
`endif

    // Grant, due-time computation and queue control
    always_comb begin
        now_next_s = now_r + 32'd1;
        lat_s      = (resp_latency < MIN_LATENCY) ? MIN_LATENCY : resp_latency;
        cand_s     = now_r + {16'h0000, lat_s};
        chain_s    = last_due_r + 32'd1;
        // last_due is only meaningful while older entries are still queued
        if ((count_s != '0) && !is_due(chain_s, cand_s)) due_s = chain_s;
        else                                              due_s = cand_s;
        // Pop one cycle early so the registered rvalid lands on the due cycle
        pop_s              = (count_s != '0) && is_due(head_s.due, now_next_s);
        full_or_draining_s = (count_s == CW'(MAX_OUTSTANDING)) && !pop_s;
        gnt_s              = data_mem_req && !full_or_draining_s && !stall_s && !rst;
        rd_word_s          = data_mem_we ? 32'h0000_0000 : mem_r[idx_s];
        // An idle queue cannot hold a latency-1 response, so feed it straight out
        bypass_s           = gnt_s && (count_s == '0) && (due_s == now_next_s);
        push_s             = gnt_s && !bypass_s;
        push_data_s.rdata  = rd_word_s;
        push_data_s.due    = due_s;
    end

    response_queue #(.DEPTH(MAX_OUTSTANDING)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (push_data_s),
        .head      (head_s),
        .count     (count_s),
        .full      (full_s)
    );

    // Cycle counter, response chaining and registered response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            now_r      <= 32'd0;
            last_due_r <= 32'd0;
            rvalid_r   <= 1'b0;
            rdata_r    <= 32'd0;
        end else begin
            now_r <= now_next_s;
            if (gnt_s) last_due_r <= due_s;
            else       last_due_r <= last_due_r;
            rvalid_r <= pop_s || bypass_s;
            if (pop_s)         rdata_r <= head_s.rdata;
            else if (bypass_s) rdata_r <= rd_word_s;
            else               rdata_r <= 32'd0;
        end
    end

    // Byte-enabled RAM writes
    always_ff @(posedge clk) begin
        if (gnt_s && data_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (data_mem_be[b]) mem_r[idx_s][8*b +: 8] <= data_mem_wdata[8*b +: 8];
            end
        end
    end

    assign data_mem_gnt    = gnt_s;
    assign data_mem_rvalid = rvalid_r;
    assign data_mem_rdata  = rdata_r;
    assign queue_full      = full_s;

endmodule

// File: tb/tb_memory_latency_responder.sv
// Directed self-checking bench for memory_latency_responder (RESPONDER_STALL_EN optional).
module tb_memory_latency_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic [15:0] lat;
    logic        qfull;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int          rv_cyc_q [$];
    logic [31:0] rv_dat_q [$];

    memory_latency_responder #(.MEM_WORDS(1024), .MAX_OUTSTANDING(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .data_mem_req    (req),
        .data_mem_addr   (addr),
        .data_mem_we     (we),
        .data_mem_be     (be),
        .data_mem_wdata  (wdata),
        .data_mem_gnt    (gnt),
        .data_mem_rvalid (rvalid),
        .data_mem_rdata  (rdata),
        .resp_latency    (lat),
        .queue_full      (qfull)
    );

    always #5 clk = ~clk;

    // Cycle index shared by grant and response timestamps
    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor
    always @(negedge clk) begin
        if (rvalid === 1'b1) begin
            rv_cyc_q.push_back(cyc);
            rv_dat_q.push_back(rdata);
        end
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [15:0] lat;
        int          exp_lat;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic align();
        @(posedge clk);
        #2;
    endtask

    // Drive a request and hold it until granted; returns with the request still driven
    task automatic issue(input logic we_i, input logic [31:0] addr_i, input logic [3:0] be_i,
                         input logic [31:0] wdata_i, input logic [15:0] lat_i, output int gcyc);
        int n;
        n = 0;
        req = 1'b1; we = we_i; addr = addr_i; be = be_i; wdata = wdata_i; lat = lat_i;
        @(negedge clk); #1;
        while (gnt !== 1'b1 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        gcyc = cyc;
        if (gnt !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: no grant within 200 cycles for addr %h", addr_i);
        end
        @(posedge clk); #2;
    endtask

    task automatic idle();
        req = 1'b0; we = 1'b0;
    endtask

    task automatic wait_rv(input string name, input int exp_cyc, input logic [31:0] exp_data);
        int n;
        int c;
        logic [31:0] d;
        n = 0;
        while (rv_cyc_q.size() == 0 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        if (rv_cyc_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no rvalid seen, expected at cycle %0d", name, exp_cyc);
        end else begin
            c = rv_cyc_q.pop_front();
            d = rv_dat_q.pop_front();
            check({name, "_cycle"}, c, exp_cyc);
            check({name, "_rdata"}, d, exp_data);
        end
    endtask

`ifdef RESPONDER_STALL_EN
    logic [15:0] lfsr_m;

    // Reference stall sequence
    always @(posedge clk) begin
        if (rst) lfsr_m <= 16'hACE1;
        else     lfsr_m <= {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
    end
`endif

    initial begin
        int g;
        int g0;
        int g1;
        int bad;
        int bad2;
        int c0;
        logic [19:0] gnt_vec;
        logic [19:0] qf_vec;
        logic prev_g;
        int ngrants;

        vecs[0] = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 16'd3, 3, 32'h0000_0000};
        vecs[1] = '{1'b0, 32'h0000_0010, 4'h0, 32'h0000_0000, 16'd5, 5, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 32'h0000_0020, 4'hF, 32'h0000_0000, 16'd1, 1, 32'h0000_0000};
        vecs[3] = '{1'b1, 32'h0000_0020, 4'h5, 32'h1122_3344, 16'd2, 2, 32'h0000_0000};
        vecs[4] = '{1'b0, 32'h0000_0020, 4'h0, 32'h0000_0000, 16'd0, 1, 32'h0022_0044};
        vecs[5] = '{1'b1, 32'h0000_1024, 4'hF, 32'hA5A5_A5A5, 16'd7, 7, 32'h0000_0000};
        vecs[6] = '{1'b0, 32'h0000_0024, 4'h0, 32'h0000_0000, 16'd1, 1, 32'hA5A5_A5A5};
        vecs[7] = '{1'b0, 32'h0000_1013, 4'h0, 32'h0000_0000, 16'd4, 4, 32'hDEAD_BEEF};
        vecs[8] = '{1'b1, 32'h0000_0024, 4'h8, 32'hFFFF_FFFF, 16'd3, 3, 32'h0000_0000};
        vecs[9] = '{1'b0, 32'h0000_0024, 4'h0, 32'h0000_0000, 16'd6, 6, 32'hFFA5_A5A5};

        rst = 1'b1; req = 1'b0; addr = 32'h0; we = 1'b0; be = 4'h0; wdata = 32'h0; lat = 16'd0;
        repeat (2) @(posedge clk);
        #2; req = 1'b1;
        @(negedge clk); #1;
        check("reset_gnt", {31'b0, gnt}, 32'd0);
        check("reset_rvalid", {31'b0, rvalid}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_queue_full", {31'b0, qfull}, 32'd0);
        req = 1'b0;
        align();
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            align();
            issue(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, vecs[i].lat, g);
            idle();
            wait_rv($sformatf("vec%0d", i), g + vecs[i].exp_lat, vecs[i].exp_rdata);
        end

`ifdef RESPONDER_STALL_EN
        // Grants must follow LFSR bit 0; latency-1 responses follow each grant
        align();
        req = 1'b1; we = 1'b0; addr = 32'h10; lat = 16'd1;
        bad = 0; bad2 = 0; ngrants = 0; prev_g = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk); #1;
            if (gnt !== ~lfsr_m[0]) bad++;
            if (rvalid !== prev_g) bad2++;
            if (gnt === 1'b1) ngrants++;
            prev_g = gnt;
        end
        align();
        idle();
        repeat (5) @(negedge clk);
        #1;
        rv_cyc_q.delete();
        rv_dat_q.delete();
        check("stall_gnt_pattern", bad, 32'd0);
        check("stall_latency", bad2, 32'd0);
        check("stall_some_grants", {31'b0, (ngrants > 100)}, 32'd1);
`else
        // Back-to-back reads with decreasing latency
        align();
        issue(1'b0, 32'h10, 4'h0, 32'h0, 16'd10, g0);
        issue(1'b0, 32'h20, 4'h0, 32'h0, 16'd10, g1);
        issue(1'b0, 32'h24, 4'h0, 32'h0, 16'd2, g);
        issue(1'b0, 32'h10, 4'h0, 32'h0, 16'd2, g);
        idle();
        wait_rv("b2b0", g0 + 10, 32'hDEAD_BEEF);
        wait_rv("b2b1", g1 + 10, 32'h0022_0044);
        wait_rv("b2b2", g1 + 11, 32'hFFA5_A5A5);
        wait_rv("b2b3", g1 + 12, 32'hDEAD_BEEF);
        repeat (20) @(negedge clk);
        #1;
        check("b2b_extra_rvalids", rv_cyc_q.size(), 32'd0);

        // Queue fills, then grant reopens in the first pop cycle
        align();
        req = 1'b1; we = 1'b0; addr = 32'h10; lat = 16'd20;
        c0 = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            if (k == 0) c0 = cyc;
            gnt_vec[k] = gnt;
            qf_vec[k]  = qfull;
        end
        align();
        idle();
        repeat (45) @(negedge clk);
        #1;
        check("full_gnt_pattern", {12'b0, gnt_vec}, 32'h0008_000F);
        check("full_qfull_pattern", {12'b0, qf_vec}, 32'h000F_FFF0);
        check("full_rvalid_count", rv_cyc_q.size(), 32'd5);
        if (rv_cyc_q.size() > 0) check("full_first_rvalid", rv_cyc_q[0], c0 + 20);
        rv_cyc_q.delete();
        rv_dat_q.delete();
`endif

        // Reset with responses pending discards them all
        align();
        issue(1'b0, 32'h10, 4'h0, 32'h0, 16'd15, g);
        issue(1'b0, 32'h20, 4'h0, 32'h0, 16'd15, g);
        issue(1'b0, 32'h24, 4'h0, 32'h0, 16'd15, g);
        idle();
        repeat (2) @(posedge clk);
        #2; rst = 1'b1;
        repeat (2) @(posedge clk);
        #2; rst = 1'b0;
        rv_cyc_q.delete();
        rv_dat_q.delete();
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk); #1;
            if (rvalid !== 1'b0) bad++;
        end
        check("reset_flush_rvalid", bad, 32'd0);
        check("reset_flush_monitor", rv_cyc_q.size(), 32'd0);
        align();
        issue(1'b0, 32'h10, 4'h0, 32'h0, 16'd1, g);
        idle();
        wait_rv("post_reset", g + 1, 32'hDEAD_BEEF);

        // Cycle counter wrap
        align();
        force dut.now_r = 32'hFFFF_FFFE;
        #1;
        release dut.now_r;
        issue(1'b0, 32'h24, 4'h0, 32'h0, 16'd4, g);
        idle();
        wait_rv("wrap", g + 4, 32'hFFA5_A5A5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
